ip_send: RTL and testbench

- IPv4 framing stage between udp_send and the MAC transmit stage.
- Takes the UDP byte stream (UDP header plus payload) and its length, and prepends a 20-byte IPv4 header.
- Header fields: version/IHL, total length, identification, DF flag, TTL, protocol 17, header checksum, source IP, destination IP.
- Streams header then UDP bytes to the MAC stage and reports the IP datagram length.

---
 rtl/ip_send.sv | 104 ++++++++++
 tb/tb_ip_send.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ip_send.sv
// ip_send: IPv4 framing stage. Prepends a 20-byte IPv4 header to the UDP byte
// stream from udp_send and streams the datagram to the MAC transmit stage.
module ip_send #(
  parameter logic [7:0]  TTL     = 8'd128,
  parameter logic [15:0] HDR_LEN = 16'd20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_enable,
  input  logic [7:0]  data_in,
  input  logic [15:0] length_in,
  input  logic [31:0] local_ip,
  input  logic [31:0] destination_ip,
  output logic        active,
  output logic [7:0]  data_out,
  output logic [15:0] length_out
);

  logic [18:0]  r_sum_a;
  logic [17:0]  r_sum_b;
  logic [19:0]  r_sum;
  logic [15:0]  r_checksum;
  logic [15:0]  r_ident;
  logic [159:0] r_shift;
  logic [15:0]  r_byte_no;
  logic         r_sending;

  logic         w_active;
  logic         w_ident_inc;
  logic [16:0]  w_fold1;
  logic [16:0]  w_fold2;
  logic [159:0] w_header;

  assign length_out = HDR_LEN + length_in;

  // The first tx_enable clock never counts as active: byte_no is still zero,
  // so the first header byte appears one clock after tx_enable rises.
  assign w_active = (tx_enable | r_sending) && (r_byte_no != 16'd0);
  assign active   = w_active;
  assign data_out = r_shift[159:152];

  assign w_header = {8'h45, 8'h00, length_out, r_ident, 16'h4000,
                     TTL, 8'h11, r_checksum, local_ip, destination_ip};

  // Second fold cannot carry out: a carry from the first fold leaves at most 0x000E below it.
  assign w_fold1 = {1'b0, r_sum[15:0]} + {13'd0, r_sum[19:16]};
  assign w_fold2 = {1'b0, w_fold1[15:0]} + {16'd0, w_fold1[16]};

  // Last active clock: the counter is about to hit zero and no reload is pending.
  assign w_ident_inc = w_active && !tx_enable && (r_byte_no == 16'd1);

  // Three-stage header checksum, frozen while a datagram is being sent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sum_a    <= 19'd0;
      r_sum_b    <= 18'd0;
      r_sum      <= 20'd0;
      r_checksum <= 16'd0;
    end else if (!w_active) begin
      r_sum_a    <= {3'd0, 16'h4500} + {3'd0, length_out} + {3'd0, r_ident}
                  + {3'd0, 16'h4000} + {3'd0, TTL, 8'h11};
      r_sum_b    <= {2'd0, local_ip[31:16]} + {2'd0, local_ip[15:0]}
                  + {2'd0, destination_ip[31:16]} + {2'd0, destination_ip[15:0]};
      r_sum      <= {1'b0, r_sum_a} + {2'd0, r_sum_b};
      r_checksum <= ~w_fold2[15:0];
    end
  end

  // Header preload while idle; byte-wide shift while sending (20-clock UDP delay).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= 160'd0;
    end else if (!w_active) begin
      r_shift <= w_header;
    end else begin
      r_shift <= {r_shift[151:0], data_in};
    end
  end

  // Remaining-byte counter; tx_enable reloads it so a re-assert extends the packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_byte_no <= 16'd0;
      r_sending <= 1'b0;
    end else if (tx_enable) begin
      r_byte_no <= length_in + 16'd19;
      r_sending <= 1'b1;
    end else if (r_byte_no != 16'd0) begin
      r_byte_no <= r_byte_no - 16'd1;
    end else begin
      r_sending <= 1'b0;
    end
  end

  // Identification advances as each datagram ends, wrapping naturally at 16 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ident <= 16'd0;
    end else if (w_ident_inc) begin
      r_ident <= r_ident + 16'd1;
    end
  end

endmodule

// File: tb/tb_ip_send.sv
// tb_ip_send: scoreboard bench for ip_send. Header bytes come from a software
// one's-complement checksum; UDP bytes are queued as they are shifted in.
module tb_ip_send;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tx_enable = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] length_in = 16'd0;
  logic [31:0] local_ip = 32'd0;
  logic [31:0] destination_ip = 32'd0;
  logic        active;
  logic [7:0]  data_out;
  logic [15:0] length_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_ident = 16'd0;
  logic [7:0]  q[$];

  ip_send dut (
    .clock(clock), .reset(reset), .tx_enable(tx_enable), .data_in(data_in),
    .length_in(length_in), .local_ip(local_ip), .destination_ip(destination_ip),
    .active(active), .data_out(data_out), .length_out(length_out)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_csum(input logic [15:0] tot_len, input logic [15:0] ident,
                                            input logic [31:0] sip, input logic [31:0] dip);
    logic [15:0] w [9];
    int unsigned s;
    w = '{16'h4500, tot_len, ident, 16'h4000, 16'h8011,
          sip[31:16], sip[15:0], dip[31:16], dip[15:0]};
    s = 0;
    for (int i = 0; i < 9; i++) begin
      s = s + int'(w[i]);
      s = (s & 32'h0000FFFF) + (s >> 16);
    end
    return ~s[15:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  // Sends one packet. Returns after the first idle clock (or after an abort by reset).
  task automatic run_packet(input string name, input logic [15:0] len, input int tx_clks,
                            input int abort_at);
    logic [159:0] hdr;
    logic [15:0]  tot;
    logic [7:0]   d;
    logic [7:0]   exp;
    int           act_cnt;
    int           budget;
    int           exp_cnt;
    bit           fell;
    tot = len + 16'd20;
    hdr = {8'h45, 8'h00, tot, m_ident, 16'h4000, 8'd128, 8'h11,
           ref_csum(tot, m_ident, local_ip, destination_ip), local_ip, destination_ip};
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(hdr[159-8*i -: 8]);
    d = 8'h30;
    act_cnt = 0;
    fell = 0;
    budget = tx_clks + int'(len) + 40;
    for (int c = 0; c < budget && !fell; c++) begin
      @(posedge clock);
      #1;
      tx_enable = (c < tx_clks);
      data_in = d;
      d = d + 8'd1;
      @(negedge clock);
      if (active === 1'b1) begin
        act_cnt++;
        exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
        n_cmp++;
        if (data_out !== exp) begin
          n_bad++;
          $display("FAIL %s byte %0d: data_out %02h expected %02h", name, act_cnt - 1, data_out, exp);
        end
        q.push_back(data_in);
        if (abort_at > 0 && act_cnt == abort_at) begin
          reset = 1'b1;
          #1;
          n_cmp++;
          if (active !== 1'b0) begin
            n_bad++;
            $display("FAIL %s async reset active: got %b expected 0", name, active);
          end
          n_cmp++;
          if (data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL %s async reset data_out: got %02h expected 00", name, data_out);
          end
          tx_enable = 1'b0;
          idle(2);
          #1 reset = 1'b0;
          m_ident = 16'd0;
          q.delete();
          return;
        end
      end else if (act_cnt > 0) begin
        fell = 1;
      end
    end
    tx_enable = 1'b0;
    // tx_enable reloads the counter every clock, so the last reload happens on its final clock.
    exp_cnt = (tx_clks - 1) + int'(len) + 19;
    n_cmp++;
    if (!fell || act_cnt != exp_cnt) begin
      n_bad++;
      $display("FAIL %s active clocks: got %0d (ended %0d) expected %0d", name, act_cnt, fell, exp_cnt);
    end
    m_ident = m_ident + 16'd1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    length_in = 16'd1032;
    local_ip = 32'hC0A8010A;
    destination_ip = 32'hC0A80114;
    idle(3);
    @(negedge clock);
    n_cmp++;
    if (active !== 1'b0) begin
      n_bad++; $display("FAIL reset active: got %b expected 0", active);
    end
    n_cmp++;
    if (data_out !== 8'h00) begin
      n_bad++; $display("FAIL reset data_out: got %02h expected 00", data_out);
    end
    n_cmp++;
    if (length_out !== 16'd1052) begin
      n_bad++; $display("FAIL reset length_out: got %0d expected 1052", length_out);
    end
    reset = 1'b0;
    m_ident = 16'd0;
    idle(5);
  endtask

  task automatic test_header_checksum;
    run_packet("hdr_1032", 16'd1032, 1032, 0);
  endtask

  task automatic test_ident_increment;
    idle(2);
    run_packet("ident_inc", 16'd1032, 1032, 0);
  endtask

  task automatic test_header_only;
    length_in = 16'd0;
    idle(5);
    @(negedge clock);
    n_cmp++;
    if (length_out !== 16'd20) begin
      n_bad++; $display("FAIL hdr_only length_out: got %0d expected 20", length_out);
    end
    run_packet("hdr_only", 16'd0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if (active !== 1'b0) begin
        n_bad++; $display("FAIL hdr_only idle %0d active: got %b expected 0", i, active);
      end
    end
  endtask

  task automatic test_ident_wrap;
    length_in = 16'd8;
    idle(2);
    force dut.r_ident = 16'hFFFF;
    idle(2);
    release dut.r_ident;
    m_ident = 16'hFFFF;
    idle(5);
    run_packet("wrap_ffff", 16'd8, 8, 0);
    idle(2);
    run_packet("wrap_0000", 16'd8, 8, 0);
  endtask

  task automatic test_reset_mid;
    length_in = 16'd64;
    local_ip = 32'h0A000001;
    destination_ip = 32'h0A0000FE;
    idle(5);
    run_packet("abort", 16'd64, 64, 30);
    idle(5);
    run_packet("after_reset", 16'd64, 64, 0);
  endtask

  task automatic test_carry;
    length_in = 16'hFFEB;
    local_ip = 32'hFFFFFFFF;
    destination_ip = 32'hFFFFFFFF;
    idle(5);
    @(negedge clock);
    n_cmp++;
    if (length_out !== 16'hFFFF) begin
      n_bad++; $display("FAIL carry length_out: got %04h expected FFFF", length_out);
    end
    run_packet("carry", 16'hFFEB, 1, 20);
  endtask

  initial begin
    test_reset();
    test_header_checksum();
    test_ident_increment();
    test_header_only();
    test_ident_wrap();
    test_reset_mid();
    test_carry();
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
